btn_conditioner: RTL and testbench

//  Conditions the raw board push-buttons (up/down/left/right) before they reach cursor_ctrl.
//  Per button: 2-FF synchronizer into clk, counter-based debounce, one-cycle press pulse,

---
 rtl/btn_conditioner_if.sv | 45 ++++
 rtl/btn_conditioner.sv | 197 +++++++++++++++++++
 tb/tb_btn_conditioner.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/btn_conditioner_if.sv
// ----------------------------------------------------------------------------
// btn_conditioner_if
//
// Purpose:
//     Groups the push-button signals exchanged between the board pins and the
//     button conditioner. The raw button vector flows into the conditioner.
//     The debounced level and the one-cycle press and release pulses flow back
//     out towards cursor_ctrl.
//
// Signals (all NUM_BTN wide, one bit per button channel):
//     btn_raw      asynchronous, bouncy, active-high button pins
//     btn_level    debounced button level
//     btn_press    one-cycle pulse on the initial press and on every auto-repeat
//     btn_release  one-cycle pulse when the debounced level falls
//
// Modports:
//     master   drives btn_raw and observes the conditioned outputs
//     slave    the conditioner itself: reads btn_raw and drives the outputs
// ----------------------------------------------------------------------------
interface btn_conditioner_if #(
    parameter int NUM_BTN = 4
) ();

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;

    // The board side (or a testbench) owns the raw pins and watches the results.
    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    // The conditioner consumes the raw pins and produces the cleaned signals.
    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release
    );

endinterface

// File: rtl/btn_conditioner.sv
// ----------------------------------------------------------------------------
// btn_conditioner
//
// Purpose:
//     Conditions the raw board push-buttons (up/down/left/right) before they
//     reach cursor_ctrl. Every channel is handled independently:
//       1. a two-flop synchronizer brings the asynchronous pin into clk,
//       2. a counter-based debouncer accepts a new level only after it has
//          stayed stable for DEB_CYCLES cycles,
//       3. a repeat FSM emits a one-cycle press pulse on the first press,
//          optional auto-repeat pulses while the button is held, and a
//          one-cycle release pulse when the debounced level falls.
//     cursor_ctrl consumes btn_press only, so one physical press moves the
//     cursor exactly once (plus any auto-repeats).
//
// Parameters:
//     NUM_BTN     number of independent button channels
//     DEB_CYCLES  cycles a new level must persist to be accepted (>= 2)
//     RPT_EN      1 = auto-repeat enabled, 0 = single press pulse per hold
//     RPT_DELAY   cycles from the first press pulse to the first repeat pulse
//     RPT_PERIOD  cycles between subsequent repeat pulses (>= 1)
//     CNT_W       counter width, must hold max(DEB_CYCLES, RPT_DELAY, RPT_PERIOD)
//
// Ports:
//     clk   in     LCD pixel clock, all logic on the rising edge
//     rst   in     synchronous, active-high reset
//     bus   slave  btn_raw in; btn_level, btn_press, btn_release out
//                  (the interface width must equal NUM_BTN)
// ----------------------------------------------------------------------------
module btn_conditioner #(
    parameter int NUM_BTN    = 4,
    parameter int DEB_CYCLES = 330000,
    parameter bit RPT_EN     = 1'b1,
    parameter int RPT_DELAY  = 16500000,
    parameter int RPT_PERIOD = 3300000,
    parameter int CNT_W      = 25
) (
    input  logic             clk,
    input  logic             rst,
    btn_conditioner_if.slave bus
);

    // ------------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rptState_e;

    // Terminal counts. Every counter compares with == against one of these and
    // is cleared on the same cycle, so none of them can ever wrap.
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(RPT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_LAST   = CNT_W'(RPT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;
    logic [NUM_BTN-1:0] level_q;
    logic [NUM_BTN-1:0] level_d;
    logic [NUM_BTN-1:0] press_q;
    logic [NUM_BTN-1:0] release_q;

    logic [CNT_W-1:0]   debCnt_q [NUM_BTN];
    logic [CNT_W-1:0]   debCnt_d [NUM_BTN];
    logic [CNT_W-1:0]   rptCnt_q [NUM_BTN];
    rptState_e          state_q  [NUM_BTN];

    // ------------------------------------------------------------------------
    // Debounce next-state logic.
    // While the synchronized input agrees with the accepted level the counter
    // is held at zero, so any reversion before acceptance restarts the count.
    // While it disagrees the counter climbs; on the cycle it reaches
    // DEB_CYCLES-1 with the input still different, the level toggles and the
    // counter clears. With the two synchronizer flops in front, a steady new
    // pin value shows up on btn_level DEB_CYCLES+2 edges after it is first
    // sampled.
    // ------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            level_d[i]  = level_q[i];
            debCnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (debCnt_q[i] == DEB_LAST) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    debCnt_d[i] = debCnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Synchronizer and debounce registers.
    // btn_raw is only ever read here into the first flop; the debouncer looks
    // at the second flop alone, so metastability never reaches real logic.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                debCnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= bus.btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                debCnt_q[i] <= debCnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Repeat FSM, one per channel, with registered press/release outputs.
    // It reacts to the edge between level_q and level_d so that the press or
    // release pulse lands on the very same edge that updates btn_level.
    // A falling level wins over everything else: it emits the release pulse,
    // suppresses any repeat pulse that would have coincided, and returns to
    // IDLE. Reset clears the state silently, so a button still held when
    // reset drops is seen as a brand-new press after the debounce time.
    // With repeat disabled the FSM parks in REPEAT and never pulses again
    // until the button is released.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                rptCnt_q[i] <= '0;
                state_q[i]  <= IDLE;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                press_q[i]   <= 1'b0;
                release_q[i] <= 1'b0;

                if (level_q[i] && !level_d[i]) begin
                    release_q[i] <= 1'b1;
                    rptCnt_q[i]  <= '0;
                    state_q[i]   <= IDLE;
                end else begin
                    case (state_q[i])
                        IDLE: begin
                            rptCnt_q[i] <= '0;
                            if (!level_q[i] && level_d[i]) begin
                                press_q[i] <= 1'b1;
                                state_q[i] <= RPT_EN ? DELAY : REPEAT;
                            end
                        end

                        DELAY: begin
                            if (rptCnt_q[i] == DELAY_LAST) begin
                                press_q[i]  <= 1'b1;
                                rptCnt_q[i] <= '0;
                                state_q[i]  <= REPEAT;
                            end else begin
                                rptCnt_q[i] <= rptCnt_q[i] + CNT_ONE;
                            end
                        end

                        REPEAT: begin
                            if (!RPT_EN) begin
                                rptCnt_q[i] <= '0;
                            end else if (rptCnt_q[i] == RPT_LAST) begin
                                press_q[i]  <= 1'b1;
                                rptCnt_q[i] <= '0;
                            end else begin
                                rptCnt_q[i] <= rptCnt_q[i] + CNT_ONE;
                            end
                        end

                        default: begin
                            rptCnt_q[i] <= '0;
                            state_q[i]  <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // All outputs come straight from flops.
    // ------------------------------------------------------------------------
    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// ----------------------------------------------------------------------------
// tb_btn_conditioner
//
// Purpose:
//     Self-checking bench for btn_conditioner. Two instances run side by side:
//     dutA with auto-repeat enabled and dutB with auto-repeat disabled, both
//     with short debounce/repeat times. Stimulus tasks drive the raw pins and
//     push hand-computed expected output events (cycle, level, press, release)
//     into a per-instance queue. A monitor watches each instance on the
//     falling clock edge; whenever an instance shows a press, a release or a
//     level change it pops the next expected event and compares it.
//
// Cycle numbering: cyc counts rising edges. Raw pins change on a falling edge
// while cyc == T, so the first edge that samples them is T+1 and the
// debounced level plus press/release land on edge T+6 (DEB_CYCLES+2).
// ----------------------------------------------------------------------------
module tb_btn_conditioner;

    localparam int NB  = 4;
    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;
    localparam int CW  = 25;

    typedef struct {
        int       cyc;
        logic [3:0] level;
        logic [3:0] press;
        logic [3:0] rel;
    } evt_t;

    logic clk;
    logic rstA;
    logic rstB;
    int   cyc;
    bit   monEn;
    int   checkCount;
    int   passCount;
    int   t;

    logic [3:0] prevA;
    logic [3:0] prevB;

    evt_t qA[$];
    evt_t qB[$];

    btn_conditioner_if #(.NUM_BTN(NB)) busA ();
    btn_conditioner_if #(.NUM_BTN(NB)) busB ();

    btn_conditioner #(
        .NUM_BTN    (NB),
        .DEB_CYCLES (DEB),
        .RPT_EN     (1'b1),
        .RPT_DELAY  (RD),
        .RPT_PERIOD (RP),
        .CNT_W      (CW)
    ) dutA (
        .clk (clk),
        .rst (rstA),
        .bus (busA)
    );

    btn_conditioner #(
        .NUM_BTN    (NB),
        .DEB_CYCLES (DEB),
        .RPT_EN     (1'b0),
        .RPT_DELAY  (RD),
        .RPT_PERIOD (RP),
        .CNT_W      (CW)
    ) dutB (
        .clk (clk),
        .rst (rstB),
        .bus (busB)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising-edge counter used to time-stamp every observed event.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Compares one value, counts it and reports a failure line if needed.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s actual=%0h required=%0h (cyc=%0d)", name, act, exp, cyc);
        end else begin
            passCount++;
        end
    endtask

    // Drives the raw pins of one instance at the current falling edge.
    task automatic applyStimulus(input int dutId, input logic [3:0] raw);
        if (dutId == 0) busA.btn_raw = raw;
        else            busB.btn_raw = raw;
    endtask

    // Queues one expected output event for one instance.
    task automatic pushEvt(input int dutId, input int c, input logic [3:0] lvl,
                           input logic [3:0] pr, input logic [3:0] rl);
        evt_t e;
        e.cyc   = c;
        e.level = lvl;
        e.press = pr;
        e.rel   = rl;
        if (dutId == 0) qA.push_back(e);
        else            qB.push_back(e);
    endtask

    // Matches one observed event against the head of the expected queue.
    task automatic matchEvent(input int dutId, input logic [3:0] lvl,
                              input logic [3:0] pr, input logic [3:0] rl);
        evt_t  e;
        bit    empty;
        string tag;
        tag   = (dutId == 0) ? "A" : "B";
        empty = (dutId == 0) ? (qA.size() == 0) : (qB.size() == 0);
        if (empty) begin
            checkCount++;
            $display("[TB] FAIL unexpected_event_%s cyc=%0d actual level=%b press=%b release=%b required=no event",
                     tag, cyc, lvl, pr, rl);
        end else begin
            if (dutId == 0) e = qA.pop_front();
            else            e = qB.pop_front();
            checkOutput({tag, "_event_cycle"}, cyc,  e.cyc);
            checkOutput({tag, "_level"},       {28'd0, lvl}, {28'd0, e.level});
            checkOutput({tag, "_press"},       {28'd0, pr},  {28'd0, e.press});
            checkOutput({tag, "_release"},     {28'd0, rl},  {28'd0, e.rel});
        end
    endtask

    // Monitor: any pulse or level change on an instance is an output event.
    always @(negedge clk) begin
        if (monEn) begin
            if (busA.btn_press != 4'd0 || busA.btn_release != 4'd0 || busA.btn_level !== prevA)
                matchEvent(0, busA.btn_level, busA.btn_press, busA.btn_release);
            if (busB.btn_press != 4'd0 || busB.btn_release != 4'd0 || busB.btn_level !== prevB)
                matchEvent(1, busB.btn_level, busB.btn_press, busB.btn_release);
        end
        prevA = busA.btn_level;
        prevB = busB.btn_level;
    end

    // Directed scenarios.
    initial begin
        checkCount = 0;
        passCount  = 0;
        monEn      = 1'b0;
        rstA       = 1'b1;
        rstB       = 1'b1;
        busA.btn_raw = 4'd0;
        busB.btn_raw = 4'd0;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("rst_level_A",   {28'd0, busA.btn_level},   32'd0);
        checkOutput("rst_press_A",   {28'd0, busA.btn_press},   32'd0);
        checkOutput("rst_release_A", {28'd0, busA.btn_release}, 32'd0);
        checkOutput("rst_level_B",   {28'd0, busB.btn_level},   32'd0);
        checkOutput("rst_press_B",   {28'd0, busB.btn_press},   32'd0);
        checkOutput("rst_release_B", {28'd0, busB.btn_release}, 32'd0);
        rstA = 1'b0;
        rstB = 1'b0;
        repeat (2) @(negedge clk);
        monEn = 1'b1;

        // Clean press on channel 0 held 60 cycles, then release. The release
        // lands on the same edge a repeat pulse would have, so only the
        // release may appear there.
        $display("[TB] clean press, auto-repeat and release on channel 0");
        t = cyc;
        applyStimulus(0, 4'b0001);
        pushEvt(0, t + 6, 4'b0001, 4'b0001, 4'b0000);
        pushEvt(0, t + 26, 4'b0001, 4'b0001, 4'b0000);
        for (int k = 0; k < 4; k++) pushEvt(0, t + 34 + 8 * k, 4'b0001, 4'b0001, 4'b0000);
        pushEvt(0, t + 66, 4'b0000, 4'b0000, 4'b0001);
        repeat (60) @(negedge clk);
        applyStimulus(0, 4'b0000);
        repeat (15) @(negedge clk);

        // Glitch on channel 1: three cycles is one short of acceptance.
        $display("[TB] three-cycle glitch on channel 1");
        applyStimulus(0, 4'b0010);
        repeat (3) @(negedge clk);
        applyStimulus(0, 4'b0000);
        repeat (12) @(negedge clk);

        // Bounce on channel 2: 1,0,1,1,0 then steady 1, released before any repeat.
        $display("[TB] bounce on channel 2");
        t = cyc;
        applyStimulus(0, 4'b0100); @(negedge clk);
        applyStimulus(0, 4'b0000); @(negedge clk);
        applyStimulus(0, 4'b0100); @(negedge clk);
        applyStimulus(0, 4'b0100); @(negedge clk);
        applyStimulus(0, 4'b0000); @(negedge clk);
        applyStimulus(0, 4'b0100);
        pushEvt(0, t + 11, 4'b0100, 4'b0100, 4'b0000);
        pushEvt(0, t + 26, 4'b0000, 4'b0000, 4'b0000 | 4'b0100);
        repeat (15) @(negedge clk);
        applyStimulus(0, 4'b0000);
        repeat (15) @(negedge clk);

        // Reset mid-hold on channel 3 while in REPEAT: level drops silently,
        // then the still-held button is seen as a fresh press.
        $display("[TB] reset while channel 3 is held");
        t = cyc;
        applyStimulus(0, 4'b1000);
        pushEvt(0, t + 6,  4'b1000, 4'b1000, 4'b0000);
        pushEvt(0, t + 26, 4'b1000, 4'b1000, 4'b0000);
        pushEvt(0, t + 31, 4'b0000, 4'b0000, 4'b0000);
        repeat (30) @(negedge clk);
        rstA = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkOutput("mid_rst_level_A",   {28'd0, busA.btn_level},   32'd0);
            checkOutput("mid_rst_press_A",   {28'd0, busA.btn_press},   32'd0);
            checkOutput("mid_rst_release_A", {28'd0, busA.btn_release}, 32'd0);
        end
        rstA = 1'b0;
        pushEvt(0, t + 38, 4'b1000, 4'b1000, 4'b0000);
        repeat (8) @(negedge clk);
        applyStimulus(0, 4'b0000);
        pushEvt(0, t + 46, 4'b0000, 4'b0000, 4'b1000);
        repeat (12) @(negedge clk);

        // Simultaneous press on channels 0 and 1 with auto-repeat disabled.
        $display("[TB] simultaneous press with repeat disabled");
        t = cyc;
        applyStimulus(1, 4'b0011);
        pushEvt(1, t + 6, 4'b0011, 4'b0011, 4'b0000);
        pushEvt(1, t + 56, 4'b0000, 4'b0000, 4'b0011);
        repeat (50) @(negedge clk);
        applyStimulus(1, 4'b0000);
        repeat (15) @(negedge clk);

        // Anything still queued was never produced.
        monEn = 1'b0;
        foreach (qA[k]) begin
            checkCount++;
            $display("[TB] FAIL missing_event_A actual=none required cyc=%0d level=%b press=%b release=%b",
                     qA[k].cyc, qA[k].level, qA[k].press, qA[k].rel);
        end
        foreach (qB[k]) begin
            checkCount++;
            $display("[TB] FAIL missing_event_B actual=none required cyc=%0d level=%b press=%b release=%b",
                     qB[k].cyc, qB[k].level, qB[k].press, qB[k].rel);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
